alu_exec_ctrl: RTL

Parametrised ALU control and execute unit for the EX stage of the pipelined MIPS-subset CPU. It decodes ALUOp/funct into an ALU control code, computes single-cycle operations, and runs MUL as an iterative shift-add sequence. It uses a valid/ready handshake and drives a busy line so the hazard unit can stall IF/ID/EX while a multiply is in flight. It extends the single-cycle, fixed-width control decode with width parametrisation, SLT, an illegal-op flag, flush, and multi-cycle execution.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_iter_mul.sv | 58 +++++
 rtl/alu_exec_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: ALUOp/funct codes, ALU control
// codes, FSM states and the control decode function.
package alu_pkg;

    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        CTRL_ADD = 3'b000,
        CTRL_MUL = 3'b001,
        CTRL_SUB = 3'b010,
        CTRL_AND = 3'b011,
        CTRL_OR  = 3'b100,
        CTRL_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      illegal;
    } dec_t;

    // Reserved ALUOp falls back to ADD silently; only an unknown R-type
    // funct is reported as illegal (and still executes as ADD).
    function automatic dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        dec_t d;
        d.ctrl    = CTRL_ADD;
        d.illegal = 1'b0;
        case (aluop)
            ALUOP_SUB: d.ctrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: d.ctrl = CTRL_ADD;
                    FUNCT_MUL: d.ctrl = CTRL_MUL;
                    FUNCT_SUB: d.ctrl = CTRL_SUB;
                    FUNCT_AND: d.ctrl = CTRL_AND;
                    FUNCT_OR:  d.ctrl = CTRL_OR;
                    FUNCT_SLT: d.ctrl = CTRL_SLT;
                    default:   d.illegal = 1'b1;
                endcase
            end
            default: d.ctrl = CTRL_ADD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// Produces the low WIDTH bits of a*b after WIDTH/MUL_BITS iterations.
module alu_iter_mul
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int N  = WIDTH / MUL_BITS;
    localparam int CW = $clog2(N + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] digit;
    logic [CW-1:0]    cnt;

    // Current multiplier digit, zero-extended so the partial product stays WIDTH wide
    always_comb begin
        digit = '0;
        digit[MUL_BITS-1:0] = mplier[MUL_BITS-1:0];
    end

    // product is the accumulator after this edge's step; on the last step it is the result
    assign product = acc + mcand * digit;
    assign done    = (cnt == CW'(1));

    // Load on start, then one shift-add step per edge until the counter empties
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= CW'(N);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (cnt != '0) begin
            acc    <= product;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU control and execute: decode, single-cycle datapath, IDLE/MUL
// FSM around the iterative multiplier, and registered result outputs.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic [2:0]       ALUCtrl_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             illegal_o,
    output logic             busy_o
);

    state_e           state;
    state_e           state_next;
    dec_t             dec;
    logic             accept;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] product;

    assign dec       = alu_decode(ALUOp_i, funct_i);
    assign ready_o   = (state == ST_IDLE);
    assign busy_o    = (state == ST_MUL);
    // A flush on the same edge wins over acceptance
    assign accept    = valid_i && ready_o && !flush_i;
    assign start_mul = accept && (dec.ctrl == CTRL_MUL);

    // Single-cycle datapath; MUL goes through the iterative unit instead
    always_comb begin
        result = '0;
        case (dec.ctrl)
            CTRL_ADD: result = data1_i + data2_i;
            CTRL_SUB: result = data1_i - data2_i;
            CTRL_AND: result = data1_i & data2_i;
            CTRL_OR:  result = data1_i | data2_i;
            CTRL_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            default:  result = '0;
        endcase
    end

    alu_iter_mul #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk_i),
        .rst     (rst_i),
        .flush   (flush_i),
        .start   (start_mul),
        .a       (data1_i),
        .b       (data2_i),
        .done    (mul_done),
        .product (product)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state: enter MUL on a multiply, leave on the final step or on flush
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush_i) state_next = ST_IDLE;
    end

    // Result registers; valid_o/illegal_o are single-cycle pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ALUCtrl_o <= CTRL_ADD;
            data_o    <= '0;
            zero_o    <= 1'b1;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            if (accept) begin
                ALUCtrl_o <= dec.ctrl;
                if (!start_mul) begin
                    data_o    <= result;
                    zero_o    <= (result == '0);
                    valid_o   <= 1'b1;
                    illegal_o <= dec.illegal;
                end
            end else if (busy_o && mul_done && !flush_i) begin
                data_o  <= product;
                zero_o  <= (product == '0);
                valid_o <= 1'b1;
            end
        end
    end

endmodule
